// File: rtl/lc3_int_ctrl_pkg.sv
// lc3_int_ctrl_pkg: shared state, vector and config types for the LC-3 interrupt controller
package lc3_int_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ARB, PEND, ACK} int_state_t;
    localparam int CFG_PRIO_W = 3;
    localparam logic [7:0] VEC_PRIV = 8'h00;
    localparam logic [7:0] VEC_ILL = 8'h01;
    localparam logic [7:0] BASE_VEC_DEF = 8'h80;
    typedef struct packed {
        logic [CFG_PRIO_W-1:0] prio;
        logic                  mask;
        logic                  edge_mode;
    } int_cfg_t;
endpackage

// File: rtl/lc3_int_ctrl_arb.sv
// lc3_int_ctrl_arb: combinational highest-priority selector, ties go to the lowest index
module lc3_int_ctrl_arb #(
    parameter int N  = 8,
    parameter int PW = 3,
    parameter int IW = 3
) (
    input  logic [N-1:0]    i_elig,
    input  logic [N*PW-1:0] i_prio,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx,
    output logic [PW-1:0]   o_prio
);
    always_comb begin
        o_valid = 1'b0;
        o_idx = '0;
        o_prio = '0;
        // descending scan with >= lets a lower index take over on equal priority
        for (int i = N - 1; i >= 0; i--)
            if (i_elig[i] && (!o_valid || i_prio[i*PW +: PW] >= o_prio)) begin
                o_valid = 1'b1;
                o_idx = IW'(i);
                o_prio = i_prio[i*PW +: PW];
            end
    end
endmodule

// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl: multi-source interrupt/exception controller driving the LC-3 INT/vector/priority inputs.
// Defining LC3_INT_NMI_EN makes the highest-numbered source a non-maskable edge interrupt.
module lc3_int_ctrl
    import lc3_int_ctrl_pkg::*;
#(
    parameter int               NUM_SRC  = 8,
    parameter int               PRIO_W   = CFG_PRIO_W,
    parameter int               VEC_W    = 8,
    parameter logic [VEC_W-1:0] BASE_VEC = VEC_W'(BASE_VEC_DEF),
    localparam int              IDX_W    = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq,
    input  logic               i_cfg_we,
    input  logic [IDX_W-1:0]   i_cfg_idx,
    input  logic [PRIO_W-1:0]  i_cfg_prio,
    input  logic               i_cfg_mask,
    input  logic               i_cfg_edge,
    input  logic [PRIO_W-1:0]  i_cur_pri,
    input  logic               i_exc_priv,
    input  logic               i_exc_ill,
    input  logic               i_int_ack,
    output logic               o_int,
    output logic [VEC_W-1:0]   o_intv,
    output logic [PRIO_W-1:0]  o_intpri,
    output logic [NUM_SRC-1:0] o_pending
);
`ifdef LC3_INT_NMI_EN
    localparam logic [NUM_SRC-1:0] NMI_BIT = NUM_SRC'(1) << (NUM_SRC - 1);
`else
    localparam logic [NUM_SRC-1:0] NMI_BIT = '0;
`endif
    int_cfg_t              r_cfg [NUM_SRC];
    int_state_t            r_state, w_state_nx;
    logic [NUM_SRC-1:0]    r_irq_d, r_pending;
    logic                  r_exc_priv, r_exc_ill, r_sel_src, r_sel_ill;
    logic [IDX_W-1:0]      r_sel_idx;
    logic [NUM_SRC-1:0]    w_pend_nx, w_ok, w_elig, w_elig_nx, w_we;
    logic [NUM_SRC*PRIO_W-1:0] w_prio_flat;
    logic                  w_arb_valid, w_nmi, w_exc, w_sel_ok, w_clr_priv, w_clr_ill;
    logic [IDX_W-1:0]      w_arb_idx, w_win_idx;
    logic [PRIO_W-1:0]     w_arb_prio;

    always_comb begin
        w_pend_nx = '0;
        w_ok = '0;
        w_elig = '0;
        w_elig_nx = '0;
        w_we = '0;
        w_prio_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_prio_flat[i*PRIO_W +: PRIO_W] = PRIO_W'(r_cfg[i].prio);
            // edge pending is sticky until its own ACK; a fresh edge in that cycle still wins
            w_pend_nx[i] = (r_cfg[i].edge_mode || NMI_BIT[i])
                ? (i_irq[i] & ~r_irq_d[i]) | (r_pending[i] & ~(r_state == ACK && r_sel_src && r_sel_idx == IDX_W'(i)))
                : i_irq[i];
            w_ok[i] = (r_cfg[i].mask && PRIO_W'(r_cfg[i].prio) > i_cur_pri) || NMI_BIT[i];
            w_elig[i] = r_pending[i] & w_ok[i];
            w_elig_nx[i] = w_pend_nx[i] & w_ok[i];
            w_we[i] = i_cfg_we && i_cfg_idx == IDX_W'(i) && !NMI_BIT[i];
        end
    end

    lc3_int_ctrl_arb #(.N(NUM_SRC), .PW(PRIO_W), .IW(IDX_W)) u_arb (
        .i_elig (w_elig & ~NMI_BIT),
        .i_prio (w_prio_flat),
        .o_valid(w_arb_valid),
        .o_idx  (w_arb_idx),
        .o_prio (w_arb_prio)
    );

    assign w_nmi = |(w_elig & NMI_BIT);
    assign w_exc = r_exc_priv | r_exc_ill;
    assign w_win_idx = w_nmi ? IDX_W'(NUM_SRC - 1) : w_arb_idx;
    assign w_sel_ok = r_sel_src ? w_elig[r_sel_idx] : 1'b1;
    assign w_clr_priv = r_state == ACK && !r_sel_src && !r_sel_ill;
    assign w_clr_ill = r_state == ACK && !r_sel_src && r_sel_ill;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: w_state_nx = (|w_elig_nx || w_exc || i_exc_priv || i_exc_ill) ? ARB : IDLE;
            ARB:  w_state_nx = (w_exc || w_nmi || w_arb_valid) ? PEND : IDLE;
            PEND: w_state_nx = i_int_ack ? ACK : (!w_sel_ok && !w_exc) ? IDLE : PEND;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb o_int = r_state == PEND;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) r_cfg[i] <= '0;
            r_irq_d <= '0;
            r_pending <= '0;
            r_exc_priv <= 1'b0;
            r_exc_ill <= 1'b0;
            r_sel_src <= 1'b0;
            r_sel_ill <= 1'b0;
            r_sel_idx <= '0;
            o_intv <= '0;
            o_intpri <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (w_we[i]) r_cfg[i] <= '{prio: CFG_PRIO_W'(i_cfg_prio), mask: i_cfg_mask, edge_mode: i_cfg_edge};
            r_irq_d <= i_irq;
            r_pending <= w_pend_nx;
            r_exc_priv <= i_exc_priv | (r_exc_priv & ~w_clr_priv);
            r_exc_ill <= i_exc_ill | (r_exc_ill & ~w_clr_ill);
            if (r_state == ARB) begin
                r_sel_src <= !w_exc;
                r_sel_ill <= !r_exc_priv;
                r_sel_idx <= w_win_idx;
                o_intv <= r_exc_priv ? VEC_W'(VEC_PRIV) : r_exc_ill ? VEC_W'(VEC_ILL) : BASE_VEC + VEC_W'(w_win_idx);
                o_intpri <= w_exc ? i_cur_pri : w_nmi ? '1 : w_arb_prio;
            end
        end
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// tb_lc3_int_ctrl: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_lc3_int_ctrl;
`ifdef LC3_INT_NMI_EN
    localparam bit NMI = 1'b1;
`else
    localparam bit NMI = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, cfg_we, cfg_mask, cfg_edge, exc_priv, exc_ill, int_ack, intr;
    logic [7:0] irq, intv, pending;
    logic [2:0] cfg_idx, cfg_prio, cur_pri, intpri;
    int         n_chk = 0, n_pass = 0;
    logic [2:0] m_prio [8];
    logic       m_mask [8], m_edge [8];
    logic [7:0] m_pend;
    logic       m_priv, m_ill;

    always #5 clk = ~clk;

    lc3_int_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
        .i_cfg_prio(cfg_prio), .i_cfg_mask(cfg_mask), .i_cfg_edge(cfg_edge), .i_cur_pri(cur_pri),
        .i_exc_priv(exc_priv), .i_exc_ill(exc_ill), .i_int_ack(int_ack),
        .o_int(intr), .o_intv(intv), .o_intpri(intpri), .o_pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input int p, input bit mk, input bit e);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_prio = 3'(p); cfg_mask = mk; cfg_edge = e;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_int(input string tag);
        for (int k = 0; k < 10 && !intr; k++) tick();
        check({tag, "_int"}, intr, 1);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; irq = '0; cfg_we = 0; exc_priv = 0; exc_ill = 0; int_ack = 0; cur_pri = '0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            m_prio[i] = '0; m_mask[i] = 1'b0; m_edge[i] = NMI && i == 7;
        end
        m_pend = '0; m_priv = 1'b0; m_ill = 1'b0;
    endtask

    // -1 none, -2 privilege exception, -3 illegal opcode, else source index
    function automatic int m_winner();
        int best = -1, score = -1;
        if (m_priv) return -2;
        if (m_ill) return -3;
        if (NMI && m_pend[7]) return 7;
        for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_mask[i] && m_prio[i] > cur_pri && int'(m_prio[i]) * 16 + 15 - i > score) begin
                score = int'(m_prio[i]) * 16 + 15 - i;
                best = i;
            end
        return best;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat, lvl;
        int w, p, ev, ep;
        bit mk, e;
        cfg_idx = '0; cfg_prio = '0; cfg_mask = 0; cfg_edge = 0;
        rst_n = 1'b0; irq = '0; cfg_we = 0; exc_priv = 0; exc_ill = 0; int_ack = 0; cur_pri = '0;
        tick(2);
        check("rst_int", intr, 0);
        check("rst_intv", intv, 0);
        check("rst_intpri", intpri, 0);
        check("rst_pending", pending, 0);

        reset_dut();
        cur_pri = 2; cfg(3, 4, 1, 1);
        irq[3] = 1'b1;
        tick(); check("lat_1cyc", intr, 0);
        tick(); check("lat_2cyc", intr, 1);
        check("src3_intv", intv, 8'h83);
        check("src3_intpri", intpri, 4);
        irq = '0;
        ack(); check("src3_ack_int", intr, 0);
        tick(); check("src3_pend_clr", pending[3], 0);

        reset_dut();
        cfg(1, 5, 1, 1); cfg(6, 5, 1, 1);
        irq = 8'b0100_0010; tick(); irq = '0;
        wait_int("tie1"); check("tie_first", intv, 8'h81);
        ack();
        wait_int("tie2"); check("tie_second", intv, 8'h86);
        ack(); tick(2);

        reset_dut();
        cur_pri = 3; cfg(2, 3, 1, 0);
        irq[2] = 1'b1; tick(4); check("lvl_equal_pri", intr, 0);
        cur_pri = 2;
        wait_int("lvl"); check("lvl_intv", intv, 8'h82);
        irq[2] = 1'b0; tick(3); check("lvl_drop", intr, 0);
        irq[2] = 1'b1; tick(); tick(); check("lvl_reraise", intr, 1);

        reset_dut();
        cur_pri = 7; cfg(5, 7, 1, 1);
        irq[5] = 1'b1; tick(); irq = '0; tick(3);
        check("exc_pre", intr, 0);
        exc_ill = 1'b1; tick(); exc_ill = 1'b0;
        wait_int("exc"); check("exc_intv", intv, 8'h01);
        check("exc_intpri", intpri, 7);
        ack(); tick(4);
        check("exc_after", intr, 0);
        check("exc_src5_pend", pending[5], 1);

        reset_dut();
        cfg(0, 2, 1, 1);
        irq[0] = 1'b1; tick(); irq = '0;
        wait_int("col1"); check("col_intv1", intv, 8'h80);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq[0] = 1'b1; tick(); irq = '0;
        check("col_pend", pending[0], 1);
        wait_int("col2"); check("col_intv2", intv, 8'h80);
        ack(); tick(2);

        reset_dut();
        cur_pri = 7; cfg(7, 5, 0, 1);
        irq[7] = 1'b1; tick(); irq = '0;
        if (NMI) begin
            wait_int("nmi"); check("nmi_intv", intv, 8'h87);
            check("nmi_intpri", intpri, 7);
            ack(); tick(2);
        end else begin
            tick(5); check("nomnmi_int", intr, 0);
            check("masked_pend", pending[7], 1);
        end

        reset_dut();
        cfg(1, 0, 1, 1);
        irq[1] = 1'b1; tick(); irq = '0;
        int_ack = 1'b1; tick(); int_ack = 1'b0; tick(4);
        check("prio0_int", intr, 0);
        check("prio0_pend", pending[1], 1);

        reset_dut();
        cfg(4, 6, 1, 1);
        irq[4] = 1'b1; tick(); irq = '0;
        wait_int("midrst");
        #2 rst_n = 1'b0;
        #1 check("midrst_int", intr, 0);
        check("midrst_pend", pending, 0);
        tick(); rst_n = 1'b1; tick(4);
        check("midrst_lost", intr, 0);

        reset_dut();
        for (int it = 0; it < 40; it++) begin
            cur_pri = 7; irq = '0; tick();
            for (int i = 0; i < 8; i++) if (!m_edge[i]) m_pend[i] = 1'b0;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 1) == 1) begin
                    p = $urandom_range(0, 7); mk = $urandom_range(0, 3) != 0; e = 1'($urandom_range(0, 1));
                    cfg(i, p, mk, e);
                    if (!(NMI && i == 7)) begin
                        m_prio[i] = 3'(p); m_mask[i] = mk; m_edge[i] = e;
                        if (!e) m_pend[i] = 1'b0;
                    end
                end
            pat = 8'($urandom & $urandom);
            for (int i = 0; i < 8; i++) lvl[i] = !m_edge[i];
            cur_pri = 3'($urandom_range(0, 6));
            exc_priv = $urandom_range(0, 5) == 0;
            exc_ill = $urandom_range(0, 5) == 0;
            irq = pat;
            m_pend |= pat; m_priv |= exc_priv; m_ill |= exc_ill;
            tick();
            exc_priv = 1'b0; exc_ill = 1'b0; irq = pat & lvl;
            for (int g = 0; g < 12; g++) begin
                w = m_winner();
                if (w == -1) break;
                ev = w == -2 ? 0 : w == -3 ? 1 : 8'h80 + w;
                ep = w < 0 ? int'(cur_pri) : (NMI && w == 7) ? 7 : int'(m_prio[w]);
                wait_int("rnd");
                check("rnd_intv", intv, ev);
                check("rnd_intpri", intpri, ep);
                if (w >= 0 && !m_edge[w]) irq[w] = 1'b0;
                ack();
                if (w == -2) m_priv = 1'b0;
                else if (w == -3) m_ill = 1'b0;
                else m_pend[w] = 1'b0;
            end
            tick(4);
            check("rnd_idle", intr, 0);
            check("rnd_pending", pending, m_pend);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lc3_int_ctrl.md
Name: lc3_int_ctrl

Overview:
- Parametrised interrupt/exception controller feeding the LC-3 control FSM's INT, vector and priority inputs.
- Generalises the single-INT scheme to NUM_SRC channels, each with programmable priority, mask and level/edge mode.
- Adds synchronous exception vectors (privilege violation x00, illegal opcode x01), a registered arbiter and an explicit ack handshake with the control FSM (ack pulsed in INT0).

Parameters:
NUM_SRC, 8, number of external interrupt sources (1..16)
PRIO_W, 3, priority width; compared against PSR[10:8]
VEC_W, 8, vector width
BASE_VEC, 8'h80, vector of source 0; source i gets BASE_VEC+i

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
irq  in  NUM_SRC  raw interrupt requests, synchronous to clk
cfg_we  in  1  config write strobe
cfg_idx  in  $clog2(NUM_SRC)  source being configured
cfg_prio  in  PRIO_W  priority for cfg_idx
cfg_mask  in  1  1 = source enabled
cfg_edge  in  1  1 = rising-edge, 0 = level
cur_pri  in  PRIO_W  current PSR priority
exc_priv  in  1  privilege exception pulse
exc_ill  in  1  illegal-opcode exception pulse
int_ack  in  1  control FSM accepted request (one-cycle pulse)
INT  out  1  request to control FSM
INTV  out  VEC_W  vector of the presented request
INTPRI  out  PRIO_W  priority to load into PSR
pending  out  NUM_SRC  per-source pending status

Behaviour:
- Reset (rst low, async): INT=0, INTV=0, INTPRI=0, pending=0; all masks=0, priorities=0, modes=level; FSM=IDLE; irq history=0.
- Pending capture, every cycle: edge source sets pending[i] on irq[i] & ~irq_d[i]; level source pending[i] mirrors irq[i]. Masked sources still record pending; they are only excluded from arbitration.
- cfg_we writes prio/mask/edge for cfg_idx next edge. Changing the mode to level clears any latched edge pending. cfg_idx >= NUM_SRC is ignored.
- Eligible: pending & mask & (prio > cur_pri). Priority 0 is never eligible.
- Winner: highest prio; tie goes to the lowest index.
- Exceptions: exc_priv/exc_ill latch into sticky flags, take precedence over all sources and bypass the cur_pri compare. Vector x00/x01, INTPRI=cur_pri (unchanged). If both are set, priv wins.
- FSM:
  - IDLE: if any exception flag or eligible source -> ARB.
  - ARB (1 cycle): register winner into INTV/INTPRI -> PEND. Latency from irq edge to INT=1 is 2 cycles.
  - PEND: INT=1, INTV/INTPRI held stable. On int_ack -> ACK. If the winner loses eligibility before ack (level drop, mask cleared, cur_pri raised) and no exception is pending, drop INT -> IDLE. A new request with higher priority arriving in PEND does not preempt; it is taken after ACK.
  - ACK (1 cycle): INT=0. Clear the served edge pending or exception flag; a level source is not cleared and must be deasserted by software. -> IDLE.
- Edge arrival on the served source in the same cycle as the ACK clear: set wins, and the request is re-presented.
- int_ack outside PEND is ignored.
- Reset mid-PEND: INT drops immediately and the request is lost; edges latched before reset are discarded.

Optional Feature:
- Macro LC3_INT_NMI_EN.
- Defined: source NUM_SRC-1 is non-maskable. Always eligible regardless of mask/cur_pri, arbitrated just below exceptions, INTPRI forced to all-ones, always edge mode; cfg writes to it are ignored.
- Undefined: all sources are identical and programmable.

Decomposition:
- lc3Pkg gains:
  - IntState enum (IDLE, ARB, PEND, ACK)
  - VEC_PRIV=8'h00, VEC_ILL=8'h01, BASE_VEC default
  - IntCfg packed struct {prio, mask, edge}
- Sub-module lc3_int_arb: combinational priority/lowest-index selector over NUM_SRC eligible entries, returning valid, index and prio.

Test Plan:
- Reset, cfg src3 prio=4 mask=1 edge=1, cur_pri=2, rising irq[3] -> INT=1 two cycles later, INTV=8'h83, INTPRI=4. int_ack -> INT=0 next cycle, pending[3]=0.
- src1 prio=5 and src6 prio=5 both pending, cur_pri=0 -> INTV=8'h81. After ack, src6 served -> INTV=8'h86.
- src2 level prio=3, cur_pri=3 -> INT stays 0. Lower cur_pri to 2 -> INT=1, INTV=8'h82. Drop irq[2] before ack -> INT=0 and FSM back to IDLE.
- exc_ill pulse while src5 prio=7 is pending with cur_pri=7 -> INTV=8'h01, INTPRI=7. After ack, src5 is still not eligible (7 not > 7).
- Edge on src0 in the ACK cycle of src0 -> pending[0] stays 1, INT re-asserts with INTV=8'h80.
- With LC3_INT_NMI_EN, src7 mask=0, cur_pri=7, edge on irq[7] -> INTV=8'h87, INTPRI=3'b111. Without the macro -> INT stays 0.
